// File: rtl/ff_checker_pkg.sv
// ff_checker_pkg: shared definitions for the flip-flop checker.
//   state_e    - FSM state encoding (IDLE=0, PRIME=1, CHECK=2, HALT=3)
//   ErrCntW    - width of the mismatch counter
//   ErrCntMax  - value at which the mismatch counter saturates
package ff_checker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StCheck = 2'd2,
        StHalt  = 2'd3
    } state_e;

    localparam int unsigned ErrCntW = 8;
    localparam logic [ErrCntW-1:0] ErrCntMax = '1;

endpackage

// File: rtl/ff_ref_model.sv
// ff_ref_model: single-flop expected-value model.
//   clk, rst  - clock, synchronous active-low reset
//   clr       - clear the model to 0
//   load      - capture the next expected value from d/dut_rst
//   d         - data stimulus seen by the observed flop
//   dut_rst   - reset stimulus seen by the observed flop
//   exp_q     - expected q of the observed flop for the following cycle
module ff_ref_model #(
    parameter logic DUT_RST_ACT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic d,
    input  logic dut_rst,
    output logic exp_q
);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            exp_q <= 1'b0;
        end else if (load) begin
            exp_q <= (dut_rst == DUT_RST_ACT) ? 1'b0 : d;
        end
    end

endmodule

// File: rtl/ff_checker.sv
// ff_checker: online checker for a single D flip-flop with complement output.
//   clk, rst      - clock, synchronous active-low reset
//   en            - checking enable; 0 returns to IDLE and clears all results
//   d, dut_rst    - stimulus as driven to the observed flop
//   q, qb         - observed flop outputs
//   err           - one-cycle pulse per mismatching cycle
//   err_q, err_qb - sticky q-mismatch / complement-mismatch flags
//   err_cnt       - saturating mismatch count
//   chk_cnt       - wrapping count of checked cycles
//   state         - FSM state encoding
// Build option: define FF_CHECKER_HALT_EN to stop in HALT on the first mismatch.
module ff_checker
    import ff_checker_pkg::*;
#(
    parameter logic        DUT_RST_ACT = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               d,
    input  logic               dut_rst,
    input  logic               q,
    input  logic               qb,
    output logic               err,
    output logic               err_q,
    output logic               err_qb,
    output logic [ErrCntW-1:0] err_cnt,
    output logic [CNT_W-1:0]   chk_cnt,
    output logic [1:0]         state
);

    state_e               state_q, state_d;
    logic                 pulse_q, pulse_d;
    logic                 q_sticky_q, q_sticky_d;
    logic                 qb_sticky_q, qb_sticky_d;
    logic [ErrCntW-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     chk_cnt_q, chk_cnt_d;
    logic                 model_clr, model_load;
    logic                 exp_q;
    logic                 q_bad, qb_bad, mismatch;

    ff_ref_model #(
        .DUT_RST_ACT (DUT_RST_ACT)
    ) u_model (
        .clk     (clk),
        .rst     (rst),
        .clr     (model_clr),
        .load    (model_load),
        .d       (d),
        .dut_rst (dut_rst),
        .exp_q   (exp_q)
    );

    // exp_q holds what the flop should show now, given stimulus of the previous edge.
    assign q_bad    = (q != exp_q);
    assign qb_bad   = (qb == q);
    assign mismatch = q_bad | qb_bad;

    always_comb begin
        state_d     = state_q;
        pulse_d     = 1'b0;
        q_sticky_d  = q_sticky_q;
        qb_sticky_d = qb_sticky_q;
        err_cnt_d   = err_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        model_clr   = 1'b0;
        model_load  = 1'b0;

        if (!en) begin
            // Disable outranks everything, including a mismatch in this same cycle.
            state_d     = StIdle;
            q_sticky_d  = 1'b0;
            qb_sticky_d = 1'b0;
            err_cnt_d   = '0;
            chk_cnt_d   = '0;
            model_clr   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StPrime;
                end
                StPrime: begin
                    model_load = 1'b1;
                    state_d    = StCheck;
                end
                StCheck: begin
                    model_load = 1'b1;
                    chk_cnt_d  = chk_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        pulse_d = 1'b1;
                        if (q_bad)  q_sticky_d  = 1'b1;
                        if (qb_bad) qb_sticky_d = 1'b1;
                        if (err_cnt_q != ErrCntMax) begin
                            err_cnt_d = err_cnt_q + ErrCntW'(1);
                        end
`ifdef FF_CHECKER_HALT_EN
                        state_d = StHalt;
`else
                        state_d = StCheck;
`endif
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            pulse_q     <= 1'b0;
            q_sticky_q  <= 1'b0;
            qb_sticky_q <= 1'b0;
            err_cnt_q   <= '0;
            chk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            q_sticky_q  <= q_sticky_d;
            qb_sticky_q <= qb_sticky_d;
            err_cnt_q   <= err_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
        end
    end

    assign err     = pulse_q;
    assign err_q   = q_sticky_q;
    assign err_qb  = qb_sticky_q;
    assign err_cnt = err_cnt_q;
    assign chk_cnt = chk_cnt_q;
    assign state   = state_q;

endmodule

// File: tb/tb_ff_checker.sv
// tb_ff_checker: ff_checker paired with a behavioural d_ff (active-high reset).
// Build option: FF_CHECKER_HALT_EN selects the halting expectations.
module tb_ff_checker;

`ifdef FF_CHECKER_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        d;
    logic        dut_rst;
    logic        q;
    logic        qb;
    logic        err;
    logic        err_q;
    logic        err_qb;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt;
    logic [1:0]  state;

    // Observed flop and fault injection
    logic ff_q;
    logic fault_q;
    logic fault_qb;

    always @(posedge clk) begin
        if (dut_rst) ff_q <= 1'b0;
        else         ff_q <= d;
    end

    assign q  = fault_q ? 1'b0 : ff_q;
    assign qb = fault_qb ? q : ~q;

    ff_checker #(
        .DUT_RST_ACT (1'b1),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d       (d),
        .dut_rst (dut_rst),
        .q       (q),
        .qb      (qb),
        .err     (err),
        .err_q   (err_q),
        .err_qb  (err_qb),
        .err_cnt (err_cnt),
        .chk_cnt (chk_cnt),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {err, err_q, err_qb, err_cnt, chk_cnt, state}
    typedef struct {
        int          cyc;
        string       name;
        logic [28:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string name, input logic e, input logic eq, input logic eqb,
                            input int ecnt, input int ccnt, input int st);
        exp_t x;
        x.cyc  = cyc;
        x.name = name;
        x.vec  = {e, eq, eqb, 8'(ecnt), 16'(ccnt), 2'(st)};
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares registered outputs mid-cycle against queued expectations
    logic [28:0] mon_act;
    exp_t        mon_x;
    always @(negedge clk) begin
        mon_act = {err, err_q, err_qb, err_cnt, chk_cnt, state};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_x = sb.pop_front();
            checks++;
            if (mon_x.cyc != cyc || mon_act !== mon_x.vec) begin
                errors++;
                $display("FAIL %s @cyc %0d: got err=%b err_q=%b err_qb=%b err_cnt=%0d chk_cnt=%0d state=%0d ; want err=%b err_q=%b err_qb=%b err_cnt=%0d chk_cnt=%0d state=%0d",
                         mon_x.name, cyc, mon_act[28], mon_act[27], mon_act[26],
                         mon_act[25:18], mon_act[17:2], mon_act[1:0],
                         mon_x.vec[28], mon_x.vec[27], mon_x.vec[26],
                         mon_x.vec[25:18], mon_x.vec[17:2], mon_x.vec[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    logic [4:0] pat;

    initial begin
        pat      = 5'b01101;  // d sequence 1,0,1,1,0 read from bit 0 upward
        rst      = 1'b0;
        en       = 1'b0;
        d        = 1'b0;
        dut_rst  = 1'b1;
        fault_q  = 1'b0;
        fault_qb = 1'b0;

        // Reset state
        tick(); push_exp("reset0", 0, 0, 0, 0, 0, 0);
        tick(); push_exp("reset1", 0, 0, 0, 0, 0, 0);

        // Clean run: first edge primes, second loads model, then one check per edge
        rst     = 1'b1;
        dut_rst = 1'b0;
        en      = 1'b1;
        for (int i = 0; i < 21; i++) begin
            d = pat[i % 5];
            tick();
            push_exp("clean", 0, 0, 0, 0, (i <= 1) ? 0 : i - 1, (i == 0) ? 1 : 2);
        end

        // Forced q fault for three CHECK cycles with d=1
        d = 1'b1;
        tick(); push_exp("qf_pre", 0, 0, 0, 0, 20, 2);
        fault_q = 1'b1;
        tick(); push_exp("qf_1", 1, 1, 0, 1, 21, HALT ? 3 : 2);
        tick(); push_exp("qf_2", HALT ? 0 : 1, 1, 0, HALT ? 1 : 2, HALT ? 21 : 22, HALT ? 3 : 2);
        tick(); push_exp("qf_3", HALT ? 0 : 1, 1, 0, HALT ? 1 : 3, HALT ? 21 : 23, HALT ? 3 : 2);
        fault_q = 1'b0;
        tick(); push_exp("qf_post", 0, 1, 0, HALT ? 1 : 3, HALT ? 21 : 24, HALT ? 3 : 2);
        en = 1'b0;
        tick(); push_exp("qf_idle", 0, 0, 0, 0, 0, 0);

        // qb fault for one cycle
        en = 1'b1;
        tick(); push_exp("qb_prime", 0, 0, 0, 0, 0, 1);
        tick(); push_exp("qb_check", 0, 0, 0, 0, 0, 2);
        fault_qb = 1'b1;
        tick(); push_exp("qb_1", 1, 0, 1, 1, 1, HALT ? 3 : 2);
        fault_qb = 1'b0;
        tick(); push_exp("qb_post", 0, 0, 1, 1, HALT ? 1 : 2, HALT ? 3 : 2);
        // Mismatch present while en drops: disable wins
        fault_qb = 1'b1;
        en       = 1'b0;
        tick(); push_exp("qb_en0", 0, 0, 0, 0, 0, 0);
        fault_qb = 1'b0;

        // Flop held in reset with d=1: model expects 0, no error
        en      = 1'b1;
        dut_rst = 1'b1;
        d       = 1'b1;
        tick(); push_exp("dr_prime", 0, 0, 0, 0, 0, 1);
        tick(); push_exp("dr_load", 0, 0, 0, 0, 0, 2);
        tick(); push_exp("dr_chk1", 0, 0, 0, 0, 1, 2);
        tick(); push_exp("dr_chk2", 0, 0, 0, 0, 2, 2);

        // Checker reset mid-CHECK, then PRIME before any compare
        rst     = 1'b0;
        dut_rst = 1'b0;
        tick(); push_exp("rst_mid", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); push_exp("rst_prime", 0, 0, 0, 0, 0, 1);
        tick(); push_exp("rst_check", 0, 0, 0, 0, 0, 2);

        // 300 consecutive q mismatches
        fault_q = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 1 || n == 255 || n == 256 || n == 300) begin
                if (HALT) push_exp("sat", (n == 1) ? 1'b1 : 1'b0, 1, 0, 1, 1, 3);
                else      push_exp("sat", 1, 1, 0, (n > 255) ? 255 : n, n, 2);
            end
        end
        en = 1'b0;
        tick(); push_exp("sat_idle", 0, 0, 0, 0, 0, 0);
        fault_q = 1'b0;

        tick();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ff_checker.md
FF_CHECKER -- requirements
Module: ff_checker

Interface
REQ-001 Parameter: DUT_RST_ACT, 1, level of dut_rst that holds the observed flop in reset (q=0).
REQ-002 Parameter: CNT_W, 16, width of chk_cnt.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (rst=0 sampled at a rising clk edge resets the block).
REQ-005 en  input  1  checking enable; 0 returns the FSM to IDLE.
REQ-006 d  input  1  data stimulus as driven to the observed flop.
REQ-007 dut_rst  input  1  reset stimulus as driven to the observed flop.
REQ-008 q  input  1  observed flop output.
REQ-009 qb  input  1  observed flop complement output.
REQ-010 err  output  1  registered one-cycle pulse per mismatching cycle.
REQ-011 err_q  output  1  sticky: q mismatch seen since last IDLE.
REQ-012 err_qb  output  1  sticky: qb != ~q seen since last IDLE.
REQ-013 err_cnt  output  8  mismatching-cycle count, saturating.
REQ-014 chk_cnt  output  CNT_W  checked-cycle count, wrapping.
REQ-015 state  output  2  current FSM state encoding.

Function
REQ-016 FSM states SHALL be IDLE=0, PRIME=1, CHECK=2, HALT=3.
REQ-017 IDLE->PRIME when en=1; any state->IDLE when en=0 (priority over all other transitions).
REQ-018 PRIME SHALL last exactly one cycle, loading the model, then ->CHECK.
REQ-019 Model each cycle (PRIME/CHECK): exp_q <= (dut_rst==DUT_RST_ACT) ? 0 : d.
REQ-020 In CHECK, q_bad = (q != exp_q); qb_bad = (qb == q); mismatch = q_bad | qb_bad.
REQ-021 Check latency: stimulus sampled at edge N is compared against q/qb sampled at edge N+1; err asserts after edge N+1, for one cycle.
REQ-022 chk_cnt SHALL increment by 1 every CHECK cycle, wrapping from 2^CNT_W-1 to 0.
REQ-023 err_cnt SHALL increment on each mismatch and hold at 255.
REQ-024 err_q/err_qb SHALL set on q_bad/qb_bad and clear only on entry to IDLE or reset.
REQ-025 Entering IDLE SHALL clear err, err_q, err_qb, err_cnt, chk_cnt and the model.
REQ-026 Simultaneous mismatch and en=0: en=0 wins; no count, no err pulse.
REQ-027 err, err_cnt, chk_cnt SHALL not change in IDLE, PRIME or HALT.

Reset
REQ-028 rst=0 at an edge: state=IDLE, err=0, err_q=0, err_qb=0, err_cnt=0, chk_cnt=0, exp_q=0.
REQ-029 Reset mid-CHECK SHALL abandon the check; after release with en=1, PRIME precedes any compare.

Configuration
REQ-030 Macro FF_CHECKER_HALT_EN defined: first mismatch in CHECK moves FSM to HALT; counters and stickies freeze until en=0.
REQ-031 Macro undefined: HALT unreachable; CHECK continues after mismatches.

Structure
REQ-032 Package ff_checker_pkg SHALL hold the state encoding constants and the err_cnt width/saturation value.
REQ-033 Sub-module ff_ref_model SHALL implement the single-flop expected-value model (REQ-019); FSM and counters stay in ff_checker.

Verification
REQ-034 Bench SHALL pair ff_checker with a correct d_ff (active-high rst, DUT_RST_ACT=1), 10-time-unit clock period.
REQ-035 Clean run: en=1, toggle d 1,0,1,1,0 for 20 cycles -> err never 1, err_cnt=0, chk_cnt=19.
REQ-036 Forced fault: force q to 0 while d=1 for 3 CHECK cycles -> err pulses 3 times, err_q=1, err_qb=0, err_cnt=3.
REQ-037 qb fault: force qb=q for 1 cycle -> err_qb=1, err_q=0, err_cnt=1.
REQ-038 DUT reset: dut_rst=1, d=1 -> exp_q=0 and no error with a correct d_ff; then rst=0 for one cycle mid-CHECK -> all outputs 0 next cycle, state=IDLE, then PRIME.
REQ-039 Saturation/halt: 300 forced mismatches -> err_cnt=255 without the macro; with FF_CHECKER_HALT_EN, state=3 after the first mismatch, err_cnt=1; en=0 -> state=0 next cycle.
